ld3320_session_ctrl: RTL and testbench

Session controller for the LD3320 voice-recognition core. It enables the core, waits for a recognition result, and applies a per-session timeout with bounded retries. Each captured result code is delivered through a one-deep valid/accept output register. It sits between the LD3320 core wrapper (`ena`, `result_valid`, `result_ready`) and application logic such as LED or command decoders, replacing ad-hoc edge detection in top-level wrappers.

---
 rtl/ld3320_session_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ld3320_session_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ld3320_session_ctrl.sv
// LD3320 session controller: arms the core, waits for a synchronized result edge, applies
// timeout/retry and holds each code in a one-deep valid/accept register. Macro: LD3320_SESSION_FILTER_EN.
module ld3320_session_ctrl #(
  parameter int unsigned          TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(10_000_000),
  parameter logic [15:0]          GAP_CYCLES     = 16'd1000,
  parameter int unsigned          RETRY_MAX      = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  input  logic       core_ready,
  input  logic [7:0] core_result,
  output logic       core_ena,
  output logic [7:0] code_out,
  output logic       code_valid,
  input  logic       code_accept,
  output logic       busy,
  output logic       timeout_flag,
  output logic [3:0] retry_cnt
);

`ifdef LD3320_SESSION_FILTER_EN
  localparam bit FilterEn = 1'b1;
`else
  localparam bit FilterEn = 1'b0;
`endif

  localparam logic [TIMEOUT_W-1:0] TmrLast  = TIMEOUT_CYCLES - TIMEOUT_W'(1);
  localparam logic [15:0]          GapLast  = GAP_CYCLES - 16'd1;
  localparam logic [3:0]           RetryMax = 4'(RETRY_MAX);

  typedef enum logic [2:0] {
    StIdle, StArm, StListen, StCapture, StHold, StGap, StFail
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic                 cont_q, cont_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [3:0]           retry_q, retry_d, retry_inc;
  logic                 tflag_q, tflag_d;
  logic [7:0]           code_q, code_d;
  logic                 valid_q, valid_d;
  logic [TIMEOUT_W-1:0] tmr_q, tmr_d;
  logic [15:0]          gap_q, gap_d;
  logic                 ena_q, ena_d;
  logic                 rise, stop_pend;

  assign rise      = sync2_q & ~prev_q;
  // A stop in the current cycle acts immediately, not one cycle later.
  assign stop_pend = stop_pend_q | stop;
  assign retry_inc = (retry_q == 4'hf) ? retry_q : retry_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    retry_d = retry_q;
    tflag_d = tflag_q;
    code_d  = code_q;
    valid_d = valid_q;
    tmr_d   = tmr_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          cont_d  = continuous;
          retry_d = 4'd0;
          tflag_d = 1'b0;
          state_d = StArm;
        end
      end
      StArm: begin
        tmr_d = '0;
        if (stop_pend) state_d = StIdle;
        else if (!sync2_q) state_d = StListen;
      end
      StListen: begin
        if (stop_pend) begin
          state_d = StIdle;
        end else if (rise) begin
          state_d = StCapture;
        end else if (tmr_q == TmrLast) begin
          retry_d = retry_inc;
          gap_d   = '0;
          state_d = (retry_inc == RetryMax) ? StFail : StGap;
        end else begin
          tmr_d = tmr_q + TIMEOUT_W'(1);
        end
      end
      StCapture: begin
        if (FilterEn && core_result == 8'h00) begin
          retry_d = retry_inc;
          gap_d   = '0;
          state_d = (retry_inc == RetryMax) ? StFail : StGap;
        end else begin
          code_d  = core_result;
          valid_d = 1'b1;
          retry_d = 4'd0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (code_accept) begin
          valid_d = 1'b0;
          if (stop_pend || !cont_q) begin
            state_d = StIdle;
          end else begin
            gap_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (stop_pend) state_d = StIdle;
        else if (gap_q == GapLast) state_d = StArm;
        else gap_d = gap_q + 16'd1;
      end
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (state_d == StFail) tflag_d = 1'b1;
    stop_pend_d = (state_d == StIdle) ? 1'b0 : stop_pend;
    ena_d       = (state_d == StArm) || (state_d == StListen);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      retry_q     <= 4'd0;
      tflag_q     <= 1'b0;
      code_q      <= 8'h00;
      valid_q     <= 1'b0;
      tmr_q       <= '0;
      gap_q       <= '0;
      ena_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= core_ready;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      retry_q     <= retry_d;
      tflag_q     <= tflag_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      tmr_q       <= tmr_d;
      gap_q       <= gap_d;
      ena_q       <= ena_d;
    end
  end

  assign core_ena     = ena_q;
  assign code_out     = code_q;
  assign code_valid   = valid_q;
  assign busy         = (state_q != StIdle);
  assign timeout_flag = tflag_q;
  assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_ld3320_session_ctrl.sv
// Directed bench for ld3320_session_ctrl: a vector table for the basic session plus
// hand-written sequences for timeout/retry, stale ready, held codes, gaps, filter and reset.
module tb_ld3320_session_ctrl;

  localparam int Gap = 20;

  logic       sys_clk, sys_rst, start, stop, continuous, core_ready, code_accept;
  logic [7:0] core_result, code_out;
  logic       core_ena, code_valid, busy, timeout_flag;
  logic [3:0] retry_cnt;

  int errors = 0;
  int checks = 0;

  ld3320_session_ctrl #(
    .TIMEOUT_W     (24),
    .TIMEOUT_CYCLES(24'd120),
    .GAP_CYCLES    (16'd20),
    .RETRY_MAX     (3)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .stop        (stop),
    .continuous  (continuous),
    .core_ready  (core_ready),
    .core_result (core_result),
    .core_ena    (core_ena),
    .code_out    (code_out),
    .code_valid  (code_valid),
    .code_accept (code_accept),
    .busy        (busy),
    .timeout_flag(timeout_flag),
    .retry_cnt   (retry_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       start, stop, cont, ready;
    logic [7:0] result;
    logic       accept;
    int         cycles;
    logic       ena, valid;
    logic [7:0] code;
    logic       busy;
  } vec_t;

  vec_t vecs [8];

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    core_ready = 1'b0; core_result = 8'h00; code_accept = 1'b0;
    tick(2);
    sys_rst = 1'b0;
  endtask

  task automatic begin_session(input logic cont);
    continuous = cont; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n = 0;
    while (!code_valid && n < max_cycles) begin
      tick(1);
      n++;
    end
    chk1({name, "_valid_seen"}, code_valid, 1'b1);
  endtask

  task automatic accept_once();
    code_accept = 1'b1;
    tick(1);
    code_accept = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          st    sp    ct    rdy   result  acc   cyc  ena   val   code    busy
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2,  1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1,  1'b1, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 99, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 3,  1'b0, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1,  1'b0, 1'b1, 8'h05, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 5,  1'b0, 1'b1, 8'h05, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1,  1'b0, 1'b0, 8'h05, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5,  1'b0, 1'b0, 8'h05, 1'b0};

    // Basic single-shot session, rise-to-valid latency of 4 cycles
    do_reset();
    chk1("rst_tflag", timeout_flag, 1'b0);
    chki("rst_retry", int'(retry_cnt), 0);
    for (int i = 0; i < 8; i++) begin
      start = vecs[i].start; stop = vecs[i].stop; continuous = vecs[i].cont;
      core_ready = vecs[i].ready; core_result = vecs[i].result; code_accept = vecs[i].accept;
      tick(vecs[i].cycles);
      chk1($sformatf("v%0d_ena", i), core_ena, vecs[i].ena);
      chk1($sformatf("v%0d_valid", i), code_valid, vecs[i].valid);
      chk8($sformatf("v%0d_code", i), code_out, vecs[i].code);
      chk1($sformatf("v%0d_busy", i), busy, vecs[i].busy);
    end

    // Three timeouts in continuous mode end in FAIL
    do_reset();
    begin_session(1'b1);
    tick(120);
    chki("to_retry_before", int'(retry_cnt), 0);
    chk1("to_ena_before", core_ena, 1'b1);
    tick(1);
    chki("to_retry_exact", int'(retry_cnt), 1);
    chk1("to_ena_after", core_ena, 1'b0);
    begin
      int   n = 0;
      int   rises = 0;
      logic prev_ena = core_ena;
      while (busy && n < 2000) begin
        tick(1);
        n++;
        if (core_ena && !prev_ena) rises++;
        prev_ena = core_ena;
      end
      chk1("to_idle", busy, 1'b0);
      chki("to_rearms", rises, 2);
    end
    chk1("to_tflag", timeout_flag, 1'b1);
    chki("to_retry_final", int'(retry_cnt), 3);
    chk1("to_ena_idle", core_ena, 1'b0);
    begin_session(1'b0);
    chk1("restart_tflag_clr", timeout_flag, 1'b0);
    chki("restart_retry_clr", int'(retry_cnt), 0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk1("stop_in_arm", busy, 1'b0);
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    chk1("start_stop_idle", busy, 1'b0);
    chk1("start_stop_ena", core_ena, 1'b0);

    // Stale ready held high keeps the controller in ARM
    do_reset();
    core_ready = 1'b1; core_result = 8'h77;
    tick(5);
    begin_session(1'b0);
    tick(200);
    chk1("stale_ena", core_ena, 1'b1);
    chk1("stale_valid", code_valid, 1'b0);
    chki("stale_retry", int'(retry_cnt), 0);
    core_ready = 1'b0; core_result = 8'h11;
    tick(5);
    core_ready = 1'b1;
    wait_valid("stale", 20);
    chk8("stale_code", code_out, 8'h11);
    accept_once();
    core_ready = 1'b0;
    tick(10);
    chk1("stale_no_second", code_valid, 1'b0);
    chk1("stale_idle", busy, 1'b0);

    // Code held through a long withheld accept with stop pulses
    do_reset();
    begin_session(1'b1);
    tick(10);
    core_ready = 1'b1; core_result = 8'h33;
    wait_valid("hold", 20);
    core_ready = 1'b0;
    begin
      int bad = 0;
      for (int i = 0; i < 500; i++) begin
        stop = (i % 50 == 0);
        tick(1);
        if (!code_valid || code_out !== 8'h33) bad++;
      end
      stop = 1'b0;
      chki("hold_stable", bad, 0);
    end
    accept_once();
    chk1("hold_valid_clr", code_valid, 1'b0);
    chk1("hold_idle", busy, 1'b0);
    tick(30);
    chk1("hold_no_rearm", core_ena, 1'b0);

    // Continuous mode: two codes in order with a full gap between them
    do_reset();
    begin_session(1'b1);
    tick(10);
    core_ready = 1'b1; core_result = 8'h01;
    wait_valid("cont1", 20);
    chk8("cont1_code", code_out, 8'h01);
    core_ready = 1'b0;
    accept_once();
    chk1("cont1_valid_clr", code_valid, 1'b0);
    chk1("cont1_busy_gap", busy, 1'b1);
    begin
      int n = 0;
      while (!core_ena && n < 200) begin
        tick(1);
        n++;
      end
      chki("cont_gap_len", n, Gap);
    end
    tick(10);
    core_ready = 1'b1; core_result = 8'h02;
    wait_valid("cont2", 20);
    chk8("cont2_code", code_out, 8'h02);
    core_ready = 1'b0;
    stop = 1'b1;
    accept_once();
    stop = 1'b0;
    chk1("cont2_stop_idle", busy, 1'b0);

    // No-match code 8'h00
    do_reset();
    begin_session(1'b0);
    tick(10);
    core_ready = 1'b1; core_result = 8'h00;
`ifdef LD3320_SESSION_FILTER_EN
    tick(10);
    core_ready = 1'b0;
    chk1("nomatch_no_valid", code_valid, 1'b0);
    chki("nomatch_retry", int'(retry_cnt), 1);
    begin
      int n = 0;
      while (!core_ena && n < 100) begin
        tick(1);
        n++;
      end
      chk1("nomatch_rearm", core_ena, 1'b1);
    end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk1("nomatch_stop", busy, 1'b0);
`else
    wait_valid("nomatch", 20);
    chk8("nomatch_code", code_out, 8'h00);
    core_ready = 1'b0;
    accept_once();
    chk1("nomatch_idle", busy, 1'b0);
`endif

    // Reset mid-session drops the pending code
    do_reset();
    begin_session(1'b1);
    tick(10);
    core_ready = 1'b1; core_result = 8'h5a;
    wait_valid("midrst", 20);
    chk8("midrst_code_pre", code_out, 8'h5a);
    sys_rst = 1'b1;
    tick(1);
    chk1("midrst_valid", code_valid, 1'b0);
    chk8("midrst_code", code_out, 8'h00);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_ena", core_ena, 1'b0);
    sys_rst = 1'b0; core_ready = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
